// File: rtl/feature_frame_assembler_pkg.sv
// Shared frame geometry and mode encoding for the feature frame assembler.
// Everything that depends on channel count or beat width is derived here.
package feature_frame_assembler_pkg;

  localparam int TOTAL_NUM_CHANNEL = 214;
  localparam int CHANNEL_WIDTH     = 2;
  localparam int BEAT_CHANNELS     = 8;

  localparam int BEATS   = (TOTAL_NUM_CHANNEL + BEAT_CHANNELS - 1) / BEAT_CHANNELS;
  localparam int REM     = TOTAL_NUM_CHANNEL - (BEATS - 1) * BEAT_CHANNELS;
  localparam int CNT_W   = $clog2(BEATS);
  localparam int BEAT_W  = BEAT_CHANNELS * CHANNEL_WIDTH;
  localparam int FRAME_W = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH;

  typedef enum logic {
    FILL    = 1'b0,
    DISCARD = 1'b1
  } mode_e;

endpackage

// File: rtl/feature_frame_assembler_if.sv
// Beat input stream, assembled-frame output and framing-error status.
// The master drives beats and consumes frames; the slave is the assembler.
interface feature_frame_assembler_if;
  import feature_frame_assembler_pkg::*;

  logic [BEAT_W-1:0]  din;
  logic               din_valid;
  logic               din_last;
  logic               din_ready;
  logic [FRAME_W-1:0] features_top;
  logic               fout_valid;
  logic               fout_ready;
  logic               frame_err;
  logic               frame_err_clr;

  modport master (
    output din, din_valid, din_last, fout_ready, frame_err_clr,
    input  din_ready, features_top, fout_valid, frame_err
  );

  modport slave (
    input  din, din_valid, din_last, fout_ready, frame_err_clr,
    output din_ready, features_top, fout_valid, frame_err
  );

endinterface

// File: rtl/feature_frame_assembler_frame_buffer.sv
// One frame of storage; a write places the beat lanes at their channel slots.
// Channel 0 sits in the MSBs; lanes past the last channel are never stored.
module frame_buffer
  import feature_frame_assembler_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [CNT_W-1:0]   beat_idx,
  input  logic [BEAT_W-1:0]  lanes,
  output logic [FRAME_W-1:0] frame
);

  logic [FRAME_W-1:0] frame_q;
  logic [FRAME_W-1:0] frame_d;

  generate
    for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      for (genvar gj = 0; gj < BEAT_CHANNELS; gj++) begin : g_lane
        if (gi < BEATS - 1 || gj < REM) begin : g_ch
          localparam int               CH   = gi * BEAT_CHANNELS + gj;
          localparam logic [CNT_W-1:0] BIDX = CNT_W'(gi);
          assign frame_d[(TOTAL_NUM_CHANNEL-1-CH)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
            (we && beat_idx == BIDX) ? lanes[gj*CHANNEL_WIDTH +: CHANNEL_WIDTH]
                                     : frame_q[(TOTAL_NUM_CHANNEL-1-CH)*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    frame_q <= frame_d;
  end

  assign frame = frame_q;

endmodule

// File: rtl/feature_frame_assembler.sv
// Ping-pong frame assembler: beats fill one buffer while the other is offered.
// Framing errors drop the partial frame and raise a sticky frame_err.
module feature_frame_assembler
  import feature_frame_assembler_pkg::*;
(
  input  logic clk,
  input  logic rst,
  feature_frame_assembler_if.slave bus
);

  mode_e            mode_q, mode_d;
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             frame_err_q, frame_err_d;

  logic             wr_en;
  logic             err_set;
  logic             accept;
  logic             last_slot;
  logic             pop;
  logic [FRAME_W-1:0] frames [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= FILL;
      full_q      <= '0;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      beat_cnt_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      full_q      <= full_d;
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      beat_cnt_q  <= beat_cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    mode_d     = mode_q;
    full_d     = full_q;
    wr_sel_d   = wr_sel_q;
    rd_sel_d   = rd_sel_q;
    beat_cnt_d = beat_cnt_q;
    wr_en      = 1'b0;
    err_set    = 1'b0;

    accept    = bus.din_valid && !full_q[wr_sel_q];
    last_slot = (beat_cnt_q == CNT_W'(BEATS - 1));
    pop       = full_q[rd_sel_q] && bus.fout_ready;

    // A pop and a completion always target different buffers, so order is free.
    if (pop) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end

    case (mode_q)
      FILL: begin
        if (accept) begin
          if (!last_slot) begin
            if (bus.din_last) begin
              err_set    = 1'b1;
              beat_cnt_d = '0;
            end else begin
              wr_en      = 1'b1;
              beat_cnt_d = beat_cnt_q + 1'b1;
            end
          end else if (bus.din_last) begin
            wr_en            = 1'b1;
            full_d[wr_sel_q] = 1'b1;
            wr_sel_d         = !wr_sel_q;
            beat_cnt_d       = '0;
          end else begin
            err_set    = 1'b1;
            mode_d     = DISCARD;
            beat_cnt_d = '0;
          end
        end
      end
      DISCARD: begin
        if (accept && bus.din_last) begin
          mode_d     = FILL;
          beat_cnt_d = '0;
        end
      end
      default: mode_d = FILL;
    endcase

    frame_err_d = err_set || (frame_err_q && !bus.frame_err_clr);
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      frame_buffer u_buf (
        .clk      (clk),
        .we       (wr_en && (wr_sel_q == 1'(gi))),
        .beat_idx (beat_cnt_q),
        .lanes    (bus.din),
        .frame    (frames[gi])
      );
    end
  endgenerate

  assign bus.din_ready    = !full_q[wr_sel_q];
  assign bus.fout_valid   = full_q[rd_sel_q];
  assign bus.features_top = frames[rd_sel_q];
  assign bus.frame_err    = frame_err_q;

endmodule

// File: doc/feature_frame_assembler.md
Name: feature_frame_assembler

Overview:
- Upstream stage of the HDC sensor-fusion top. Accepts quantised physiological features as a narrow beat stream from the FPGA/host link.
- Assembles one full frame of TOTAL_NUM_CHANNEL features and presents it as the flat features_top vector with a valid/ready handshake into the fusion core's fin_valid/fin_ready.
- Double-buffered (ping-pong), so the next frame can stream in while the core holds the current one.

Parameters:
- TOTAL_NUM_CHANNEL, 214: channels per frame (GSR 32 + ECG 77 + EEG 105).
- CHANNEL_WIDTH, 2: bits per channel feature.
- BEAT_CHANNELS, 8: channels carried per input beat.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- din  in  BEAT_CHANNELS*CHANNEL_WIDTH  beat payload; lane k at din[k*CHANNEL_WIDTH +: CHANNEL_WIDTH].
- din_valid  in  1  beat valid.
- din_last  in  1  marks final beat of a frame; qualified by din_valid.
- din_ready  out  1  beat accepted when din_valid && din_ready.
- features_top  out  TOTAL_NUM_CHANNEL*CHANNEL_WIDTH  assembled frame.
- fout_valid  out  1  frame valid; connects to core fin_valid.
- fout_ready  in  1  core fin_ready.
- frame_err  out  1  sticky framing-error flag.
- frame_err_clr  in  1  clears frame_err.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Frame length: BEATS = ceil(TOTAL_NUM_CHANNEL/BEAT_CHANNELS) = 27 at defaults.
  - Final beat carries REM = TOTAL_NUM_CHANNEL - (BEATS-1)*BEAT_CHANNELS = 6 valid lanes (lanes 0..REM-1). Upper lanes are ignored.
- Channel ordering:
  - Channel c = beat_idx*BEAT_CHANNELS + lane.
  - Channel c is written to features_top[(TOTAL_NUM_CHANNEL-1-c)*CHANNEL_WIDTH +: CHANNEL_WIDTH], so channel 0 occupies the MSBs.
- Storage and state:
  - Two frame buffers buf[0..1], each with a full flag.
  - wr_sel/rd_sel select the write and read buffers.
  - beat_cnt is 0..BEATS-1, width clog2(BEATS).
  - Mode state machine: FILL or DISCARD.
- din_ready = !full[wr_sel] in FILL and in DISCARD.
- Accepted beat in FILL, beat_cnt < BEATS-1, din_last=0: write lanes; beat_cnt++.
- Accepted beat in FILL, beat_cnt == BEATS-1, din_last=1: write lanes; full[wr_sel] <= 1; wr_sel toggles; beat_cnt <= 0.
- Framing errors:
  - Early last: din_last=1 with beat_cnt < BEATS-1. Set frame_err, drop the partial frame, beat_cnt <= 0, stay in FILL. The buffer is not marked full.
  - Missing last: beat_cnt == BEATS-1 and din_last=0. Set frame_err and enter DISCARD.
  - DISCARD drops accepted beats until a beat with din_last is accepted, then returns to FILL with beat_cnt=0.
- frame_err:
  - Sticky.
  - Cleared by frame_err_clr.
  - If set and clear occur in the same cycle, set wins.
- Output side:
  - fout_valid = full[rd_sel].
  - features_top = buf[rd_sel], held stable while fout_valid && !fout_ready.
  - On fout_valid && fout_ready: full[rd_sel] <= 0 and rd_sel toggles.
- Latency: fout_valid rises the cycle after the final beat is accepted, when the other buffer is empty.
- Throughput: one beat per cycle sustained. There are no bubbles across frame boundaries while the consumer keeps up.
- Simultaneous events:
  - A completion into buffer X and a pop of buffer Y in the same cycle are independent.
  - With one buffer full, a new frame may complete while the old one pops. Both flags update correctly.
  - When both buffers are full, din_ready=0.
- Reset (all synchronous):
  - full=0, wr_sel=rd_sel=0, beat_cnt=0, mode=FILL.
  - Outputs: fout_valid=0, frame_err=0, din_ready=1.
  - Buffer contents are don't-care; features_top is undefined until the first fout_valid.
  - Reset mid-frame discards the partial and any stored frames.
- No combinational path from fout_ready to din_ready.

Decomposition:
- Shared package/const header, reusing the existing defines rather than duplicating them:
  - TOTAL_NUM_CHANNEL, CHANNEL_WIDTH
  - derived BEATS, REM
  - mode enum {FILL, DISCARD}
- One natural sub-module: frame_buffer. It holds the storage for one frame with beat-indexed lane writes. It is instantiated twice, and the top holds the control.

Test Plan:
- Single frame: 27 beats, beat b lane k = (b*8+k)%4, last on beat 26 -> fout_valid on cycle after beat 26; channel c at bits [(213-c)*2+:2] equals c%4; channels 214..215 absent.
- Back-to-back: 4 frames streamed continuously, fout_ready=1 -> din_ready never drops; 4 frames out in order, no beat stalls.
- Backpressure: fout_ready=0 and 3 frames offered -> 2 frames buffered; din_ready=0 from the cycle after frame 2 completes; features_top stable; releasing fout_ready drains frame 1 then frame 2; frame 3 then fills.
- Early last: din_last on beat 10 -> frame_err=1, no fout_valid; next full 27-beat frame is delivered correctly.
- Missing last: 30 beats with last only on beat 29 -> frame_err=1, all dropped; next frame is correct; frame_err_clr clears the flag; set+clear in the same cycle leaves it 1.
- Reset at beat 13 with one frame buffered -> fout_valid=0 next cycle; a subsequent clean frame is delivered with beat_cnt restarting at 0.
